// File: rtl/rtc_arb_pkg.sv
// Shared definitions for the RTC bus arbiter: FSM encoding, client indices
// and default timing parameters.
package rtc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int CLI_INIT  = 0;
  localparam int CLI_RESET = 1;
  localparam int CLI_WRITE = 2;
  localparam int CLI_READ  = 3;

  localparam int DEF_NREQ         = 4;
  localparam int DEF_TIMEOUT      = 255;
  localparam int DEF_STARVE_LIMIT = 8;

endpackage

// File: rtl/rtc_arb_prio.sv
// Fixed-priority one-hot picker (index 0 wins). With RTC_ARB_STARVE_GUARD_EN
// defined, a saturating counter forces a grant to the last client after
// STARVE_LIMIT grants to the others while it waits.
module rtc_arb_prio #(
  parameter int NREQ         = 4,
  parameter int STARVE_LIMIT = 8
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            pick,
  output logic [NREQ-1:0] winner
);

  logic [NREQ-1:0] fixed_win;

  always_comb begin
    fixed_win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) fixed_win = NREQ'(1) << i;
    end
  end

`ifdef RTC_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          starve;

  assign starve = req[NREQ-1] && (starve_cnt >= CW'(STARVE_LIMIT));
  assign winner = starve ? (NREQ'(1) << (NREQ - 1)) : fixed_win;

  // Counts only arbitration grants; a locked burst is one grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!req[NREQ-1]) begin
      starve_cnt <= '0;
    end else if (pick) begin
      if (winner[NREQ-1])
        starve_cnt <= '0;
      else if (starve_cnt < CW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic unused_guard;
  assign unused_guard = ^{clk, rst, pick};
  assign winner       = fixed_win;
`endif

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Four-client arbiter/sequencer in front of the RTC protocol engine. Optional
// starvation guard for the periodic reader: RTC_ARB_STARVE_GUARD_EN.
module rtc_bus_arbiter
  import rtc_arb_pkg::*;
#(
  parameter int NREQ         = DEF_NREQ,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
)(
  input  logic              clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_wdata,
  input  logic [NREQ-1:0]   req_rnw,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              txn_start,
  output logic [7:0]        txn_addr,
  output logic [7:0]        txn_wdata,
  output logic              txn_rnw,
  input  logic              txn_done,
  input  logic [7:0]        txn_rdata
);

  state_e          state, nxt;
  logic [7:0]      tmo_cnt;
  logic [NREQ-1:0] winner, src;
  logic            pick, burst, tmo_hit;
  logic [7:0]      sel_addr, sel_wdata;
  logic            sel_rnw;

  assign pick    = (state == IDLE) && (|req);
  assign burst   = |(grant & lock & req);
  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT));
  assign src     = (state == IDLE) ? winner : grant;

  rtc_arb_prio #(
    .NREQ         (NREQ),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk    (clk),
    .rst    (Reset),
    .req    (req),
    .pick   (pick),
    .winner (winner)
  );

  // Field mux: the new winner in IDLE, the current owner on a burst re-issue.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rnw   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (src[i]) begin
        sel_addr  = sel_addr  | req_addr[8*i +: 8];
        sel_wdata = sel_wdata | req_wdata[8*i +: 8];
        sel_rnw   = sel_rnw   | req_rnw[i];
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (|req) nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    if (txn_done || tmo_hit) nxt = DONE;
      DONE:    nxt = burst ? ISSUE : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      grant     <= '0;
      ack       <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      txn_start <= 1'b0;
      txn_addr  <= '0;
      txn_wdata <= '0;
      txn_rnw   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      ack       <= '0;
      txn_start <= (nxt == ISSUE);
      busy      <= (nxt != IDLE);
      case (state)
        IDLE: begin
          if (|req) begin
            grant     <= winner;
            txn_addr  <= sel_addr;
            txn_wdata <= sel_wdata;
            txn_rnw   <= sel_rnw;
          end
        end
        ISSUE: tmo_cnt <= '0;
        WAIT: begin
          if (txn_done) begin
            rdata <= txn_rdata;
            err   <= 1'b0;
            ack   <= grant;
          end else if (tmo_hit) begin
            rdata <= '0;
            err   <= 1'b1;
            ack   <= grant;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          if (burst) begin
            txn_addr  <= sel_addr;
            txn_wdata <= sel_wdata;
            txn_rnw   <= sel_rnw;
          end else begin
            grant <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Scoreboarded bench for rtc_bus_arbiter with a behavioural RTC engine model.
module tb_rtc_bus_arbiter;

  logic        clk = 1'b0;
  logic        Reset;
  logic [3:0]  req, lock, req_rnw;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  grant, ack;
  logic        err, busy, txn_start, txn_rnw;
  logic [7:0]  rdata, txn_addr, txn_wdata;
  logic        txn_done;
  logic [7:0]  txn_rdata;

  rtc_bus_arbiter dut (
    .clk       (clk),
    .Reset     (Reset),
    .req       (req),
    .lock      (lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rnw   (req_rnw),
    .grant     (grant),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .txn_start (txn_start),
    .txn_addr  (txn_addr),
    .txn_wdata (txn_wdata),
    .txn_rnw   (txn_rnw),
    .txn_done  (txn_done),
    .txn_rdata (txn_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] g; logic [7:0] a; logic [7:0] w; logic r; } iss_t;
  typedef struct packed { logic [3:0] g; logic [7:0] d; logic e; } ack_t;

  iss_t iss_q[$];
  ack_t ack_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: reads return memory, writes store and echo ~wdata.
  logic [7:0] mem [256];
  int         eng_lat = 3;
  bit         eng_dead = 0;
  int         cd = 0;
  logic [7:0] e_addr, e_wdata;
  logic       e_rnw;

  initial begin
    txn_done  = 1'b0;
    txn_rdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end

  always @(negedge clk) begin
    txn_done = 1'b0;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        txn_done  = 1'b1;
        txn_rdata = e_rnw ? mem[e_addr] : ~e_wdata;
        if (!e_rnw) mem[e_addr] = e_wdata;
      end
    end
    if (txn_start === 1'b1 && !eng_dead) begin
      e_addr  = txn_addr;
      e_wdata = txn_wdata;
      e_rnw   = txn_rnw;
      cd      = eng_lat;
    end
  end

  // Scoreboard: every issue and every ack is matched against the queues.
  always @(negedge clk) begin
    if (txn_start === 1'b1) begin
      checks++;
      if (iss_q.size() == 0) begin
        $display("FAIL iss_unexpected: grant=%b addr=%h", grant, txn_addr);
      end else begin
        iss_t x;
        x = iss_q.pop_front();
        if ({grant, txn_addr, txn_wdata, txn_rnw} !== {x.g, x.a, x.w, x.r})
          $display("FAIL iss: got g=%b a=%h w=%h r=%b want g=%b a=%h w=%h r=%b",
                   grant, txn_addr, txn_wdata, txn_rnw, x.g, x.a, x.w, x.r);
        else passed++;
      end
    end
    if (ack !== 4'b0000) begin
      checks++;
      if (ack_q.size() == 0) begin
        $display("FAIL ack_unexpected: ack=%b rdata=%h err=%b", ack, rdata, err);
      end else begin
        ack_t y;
        y = ack_q.pop_front();
        if ({ack, rdata, err} !== {y.g, y.d, y.e})
          $display("FAIL ack: got ack=%b d=%h e=%b want ack=%b d=%h e=%b",
                   ack, rdata, err, y.g, y.d, y.e);
        else passed++;
      end
    end
  end

  task automatic set_cli(input int c, input logic [7:0] a, input logic [7:0] w, input logic r);
    req_addr[8*c +: 8]  = a;
    req_wdata[8*c +: 8] = w;
    req_rnw[c]          = r;
  endtask

  task automatic wait_ack(input int c, input int limit, output bit ok, output bit saw_idle);
    ok = 0;
    saw_idle = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (ack[c] === 1'b1) begin
        ok = 1;
        break;
      end
      if (busy !== 1'b1) saw_idle = 1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; req = '0; lock = '0; req_rnw = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (grant !== 4'b0) $display("FAIL rst_grant: got %b want 0", grant); else passed++;
    checks++; if (ack !== 4'b0) $display("FAIL rst_ack: got %b want 0", ack); else passed++;
    checks++; if ({err, rdata} !== 9'b0) $display("FAIL rst_rdata: got %b/%h want 0", err, rdata); else passed++;
    checks++; if ({busy, txn_start} !== 2'b0) $display("FAIL rst_busy: got %b want 00", {busy, txn_start}); else passed++;
    checks++;
    if ({txn_addr, txn_wdata, txn_rnw} !== 17'b0)
      $display("FAIL rst_txn: got %h %h %b want 0", txn_addr, txn_wdata, txn_rnw);
    else passed++;
    Reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    bit ok, si;
    mem[8'h21] = 8'h45;
    eng_lat = 5;
    set_cli(3, 8'h21, 8'h99, 1'b1);
    iss_q.push_back('{4'b1000, 8'h21, 8'h99, 1'b1});
    ack_q.push_back('{4'b1000, 8'h45, 1'b0});
    req[3] = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 4'b1000) $display("FAIL rd_grant: got %b want 1000", grant); else passed++;
    checks++; if (txn_start !== 1'b1) $display("FAIL rd_start: got %b want 1", txn_start); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL rd_busy: got %b want 1", busy); else passed++;
    @(negedge clk);
    checks++; if (txn_start !== 1'b0) $display("FAIL rd_start_pulse: got %b want 0", txn_start); else passed++;
    wait_ack(3, 50, ok, si);
    checks++; if (!ok) $display("FAIL rd_ack_timeout: got none want ack[3]"); else passed++;
    req[3] = 1'b0;
    @(negedge clk);
    checks++; if ({grant, busy} !== 5'b0) $display("FAIL rd_idle: got %b want 0", {grant, busy}); else passed++;
  endtask

  task automatic test_priority();
    bit ok, si;
    eng_lat = 2;
    mem[8'h32] = 8'h6B;
    set_cli(1, 8'h31, 8'hA1, 1'b0);
    set_cli(2, 8'h32, 8'h5C, 1'b1);
    iss_q.push_back('{4'b0010, 8'h31, 8'hA1, 1'b0});
    iss_q.push_back('{4'b0100, 8'h32, 8'h5C, 1'b1});
    ack_q.push_back('{4'b0010, 8'h5E, 1'b0});
    ack_q.push_back('{4'b0100, 8'h6B, 1'b0});
    req = 4'b0110;
    wait_ack(1, 50, ok, si);
    checks++; if (!ok) $display("FAIL prio_ack1: got none want ack[1]"); else passed++;
    req[1] = 1'b0;
    wait_ack(2, 50, ok, si);
    checks++; if (!ok) $display("FAIL prio_ack2: got none want ack[2]"); else passed++;
    req[2] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_burst();
    bit ok, si;
    eng_lat = 3;
    lock[2] = 1'b1;
    set_cli(2, 8'h21, 8'h12, 1'b0);
    set_cli(0, 8'h22, 8'h00, 1'b1);
    iss_q.push_back('{4'b0100, 8'h21, 8'h12, 1'b0});
    iss_q.push_back('{4'b0100, 8'h22, 8'h34, 1'b0});
    iss_q.push_back('{4'b0100, 8'h23, 8'h56, 1'b0});
    iss_q.push_back('{4'b0001, 8'h22, 8'h00, 1'b1});
    ack_q.push_back('{4'b0100, 8'hED, 1'b0});
    ack_q.push_back('{4'b0100, 8'hCB, 1'b0});
    ack_q.push_back('{4'b0100, 8'hA9, 1'b0});
    ack_q.push_back('{4'b0001, 8'h34, 1'b0});
    req[2] = 1'b1;
    wait_ack(2, 50, ok, si);
    checks++; if (!ok) $display("FAIL burst_ack1: got none want ack[2]"); else passed++;
    set_cli(2, 8'h22, 8'h34, 1'b0);
    req[0] = 1'b1;
    wait_ack(2, 50, ok, si);
    checks++; if (!ok || si) $display("FAIL burst_ack2: got ok=%b idle=%b want ok=1 idle=0", ok, si); else passed++;
    set_cli(2, 8'h23, 8'h56, 1'b0);
    wait_ack(2, 50, ok, si);
    checks++; if (!ok || si) $display("FAIL burst_ack3: got ok=%b idle=%b want ok=1 idle=0", ok, si); else passed++;
    lock[2] = 1'b0;
    req[2]  = 1'b0;
    wait_ack(0, 50, ok, si);
    checks++; if (!ok) $display("FAIL burst_ack0: got none want ack[0]"); else passed++;
    req[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok, si, seen;
    int t0;
    eng_dead = 1;
    seen = 0;
    t0 = 0;
    set_cli(3, 8'h40, 8'h00, 1'b1);
    iss_q.push_back('{4'b1000, 8'h40, 8'h00, 1'b1});
    ack_q.push_back('{4'b1000, 8'h00, 1'b1});
    req[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (txn_start === 1'b1) begin
        seen = 1;
        t0 = cyc;
        break;
      end
    end
    checks++; if (!seen) $display("FAIL tmo_issue: got none want txn_start"); else passed++;
    wait_ack(3, 400, ok, si);
    checks++; if (!ok) $display("FAIL tmo_ack: got none want ack[3]"); else passed++;
    checks++;
    if (cyc - t0 != 257) $display("FAIL tmo_latency: got %0d want 257", cyc - t0);
    else passed++;
    req[3] = 1'b0;
    @(negedge clk);
    checks++; if ({grant, busy} !== 5'b0) $display("FAIL tmo_idle: got %b want 0", {grant, busy}); else passed++;
    eng_dead = 0;
  endtask

  task automatic test_reset_mid();
    bit saw;
    eng_lat = 20;
    set_cli(1, 8'h10, 8'h00, 1'b1);
    iss_q.push_back('{4'b0010, 8'h10, 8'h00, 1'b1});
    req[1] = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL rstm_busy: got %b want 1", busy); else passed++;
    #2 Reset = 1'b1;
    #1;
    checks++; if ({grant, ack, busy, txn_start} !== 10'b0)
      $display("FAIL rstm_ctl: got %b want 0", {grant, ack, busy, txn_start}); else passed++;
    checks++; if ({err, rdata, txn_addr, txn_wdata, txn_rnw} !== 26'b0)
      $display("FAIL rstm_data: got %h want 0", {err, rdata, txn_addr, txn_wdata, txn_rnw}); else passed++;
    @(negedge clk);
    Reset  = 1'b0;
    req[1] = 1'b0;
    saw = 0;
    repeat (25) begin
      @(negedge clk);
      if (ack !== 4'b0 || busy !== 1'b0) saw = 1;
    end
    checks++; if (saw) $display("FAIL rstm_late_done: got activity want idle"); else passed++;
  endtask

  task automatic test_starve_guard();
    int n3, want3, got;
    eng_lat = 1;
    mem[8'h50] = 8'h77;
    set_cli(2, 8'h50, 8'h77, 1'b0);
    set_cli(3, 8'h50, 8'h00, 1'b1);
    want3 = 0;
    for (int k = 0; k < 18; k++) begin
`ifdef RTC_ARB_STARVE_GUARD_EN
      if (k % 9 == 8) begin
        want3++;
        iss_q.push_back('{4'b1000, 8'h50, 8'h00, 1'b1});
        ack_q.push_back('{4'b1000, 8'h77, 1'b0});
        continue;
      end
`endif
      iss_q.push_back('{4'b0100, 8'h50, 8'h77, 1'b0});
      ack_q.push_back('{4'b0100, 8'h88, 1'b0});
    end
    n3 = 0;
    got = 0;
    req[2] = 1'b1;
    req[3] = 1'b1;
    for (int k = 0; k < 400 && got < 18; k++) begin
      @(negedge clk);
      if (ack !== 4'b0) begin
        got++;
        if (ack[3] === 1'b1) n3++;
        if (got == 18) req = '0;
      end
    end
    req = '0;
    checks++; if (got != 18) $display("FAIL starve_acks: got %0d want 18", got); else passed++;
    checks++; if (n3 != want3) $display("FAIL starve_cli3: got %0d want %0d", n3, want3); else passed++;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_priority();
    test_burst();
    test_timeout();
    test_reset_mid();
    test_starve_guard();
    repeat (5) @(negedge clk);
    checks++;
    if (iss_q.size() != 0 || ack_q.size() != 0)
      $display("FAIL drain: got iss=%0d ack=%0d want 0/0", iss_q.size(), ack_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Sequencer and arbiter for the shared RTC transaction engine. It accepts single-register read/write requests from four clients: power-up initialisation, reset loader, user write machine and periodic read machine. It grants one client at a time under fixed priority and issues exactly one start pulse per transaction to the protocol engine. It returns completion, read data and a timeout error to the granted client. It replaces the ad-hoc address/data muxing in front of the RTC protocol engine.

## Interface
Parameters:
- `NREQ`, 4, number of requesters; index 0 has the highest priority (0 = init, 1 = reset, 2 = write, 3 = periodic read).
- `TIMEOUT`, 255, maximum cycles spent in WAIT before a transaction is aborted; 8-bit counter.
- `STARVE_LIMIT`, 8, consecutive grants to other clients allowed while req[3] is pending (used only with the macro).

Ports:
- `clk`  in  1  system clock, single clock domain.
- `Reset`  in  1  asynchronous, active-high reset.
- `req`  in  4  per-client request level, held until that client's ack.
- `lock`  in  4  per-client burst hold; keeps the grant across back-to-back transactions.
- `req_addr`  in  32  client i register address in bits [8i+7:8i].
- `req_wdata`  in  32  client i write data in bits [8i+7:8i].
- `req_rnw`  in  4  per-client direction, 1 = read.
- `grant`  out  4  one-hot owner of the engine, 0 when idle.
- `ack`  out  4  one-cycle completion pulse to the owner.
- `err`  out  1  qualifies ack; 1 = timeout abort.
- `rdata`  out  8  read data, valid while ack is high.
- `busy`  out  1  high in any state other than IDLE.
- `txn_start`  out  1  one-cycle start pulse to the protocol engine.
- `txn_addr`, `txn_wdata`  out  8 each  latched transaction fields.
- `txn_rnw`  out  1  latched direction.
- `txn_done`  in  1  engine completion pulse.
- `txn_rdata`  in  8  engine read data, valid with txn_done.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE: if any req bit is set, select the winner, latch its addr, wdata and rnw, set grant, and go to ISSUE.
- ISSUE: txn_start = 1 for this one cycle, clear the timeout counter, go to WAIT.
- WAIT: on txn_done, capture txn_rdata into rdata, set err = 0, go to DONE. When the counter reaches TIMEOUT, set err = 1, set rdata = 0x00, go to DONE. Otherwise increment the counter.
- DONE: ack[owner] = 1 for one cycle.
  - If lock[owner] && req[owner]: re-latch the owner's fields, keep grant, go to ISSUE.
  - Otherwise: grant = 0, go to IDLE.
- Requests that appear while busy wait until the next IDLE arbitration. req dropping mid-transaction does not abort it; ack still pulses.
- A client that holds req high without lock is re-arbitrated against the others and may win again.
- txn_done outside WAIT is ignored.
- Reset, including mid-transaction, forces IDLE. All outputs return to 0: grant, ack, err, rdata, busy, txn_* and the counters.

## Timing
- req seen in IDLE at cycle n: grant and txn_start are high at n+1, busy is high from n+1.
- txn_done at cycle m: ack, rdata and err are valid at m+1. Next arbitration (IDLE) or next burst issue (ISSUE) happens at m+2.
- Minimum cost per transaction: 3 cycles plus engine latency.
- Timeout: ack at ISSUE + TIMEOUT + 2 cycles.

## Configuration
- `RTC_ARB_STARVE_GUARD_EN` defined:
  - A saturating counter counts grants given to clients 0–2 while req[3] is pending.
  - When the counter reaches STARVE_LIMIT, the next IDLE arbitration grants client 3 and the counter clears.
  - The counter also clears on any grant to client 3, or when req[3] is low.
- Not defined: strict fixed priority, no counter is present, and client 3 can starve.

## Structure
- Package `rtc_arb_pkg` holds:
  - the state encoding (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3);
  - client index constants (CLI_INIT, CLI_RESET, CLI_WRITE, CLI_READ);
  - the default TIMEOUT value.
- Sub-module `rtc_arb_prio`: combinational priority picker producing a one-hot winner from req plus the starve-override input, with the starvation counter inside it under the macro.
- The FSM, field latches and timeout counter live in the top.

## Test plan
- Reset, then req = 4'b1000 read of 0x21 with the engine returning 0x45 after 5 cycles: grant = 4'b1000 and txn_start at n+1, single pulse; ack[3] = 1 with rdata = 0x45, err = 0.
- req = 4'b0110 simultaneously: client 1 is served first. Client 2 is granted in IDLE after ack[1], with txn_addr/wdata taken from its slice.
- Client 2 with lock = 1 and three writes (0x21 = 0x12, 0x22 = 0x34, 0x23 = 0x56), with req[0] raised midway: three consecutive transactions with no IDLE between them. Client 0 is granted only after lock drops.
- Engine never asserts txn_done, TIMEOUT = 255: ack with err = 1 and rdata = 0x00 exactly 257 cycles after ISSUE, then IDLE.
- Reset asserted in WAIT: same cycle, all outputs 0 and state IDLE. A late txn_done is ignored.
- With `RTC_ARB_STARVE_GUARD_EN` and STARVE_LIMIT = 8: clients 2 and 3 requesting continuously, no lock. Client 2 gets 8 grants, then client 3 gets one, and the pattern repeats. Without the macro, client 3 never gets a grant.
